// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: request/grant/response handshake to data memory, load align/extend, store lanes.
// Optional LSU_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES cycles without rvalid and raises fault.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        wb_write_enable,
  output logic        fault,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state, state_next;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        accept, illegal, misaligned, bad, timeout_hit, rsp_hit;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c, load_c;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign accept  = req_valid && (state == S_IDLE);
  assign rsp_hit = (state == S_WAIT) && mem_rvalid;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: illegal = 1'b1;
    endcase
    // Stores have no unsigned forms; loads only allow LBU/LHU with bit 2 set.
    if (funct3[2] && (is_store || funct3[1]))
      illegal = 1'b1;
    bad = illegal || misaligned;
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = store_data;
      end
    endcase
    if (!is_store)
      wstrb_c = 4'b0000;
  end

  always_comb begin
    byte_v = 8'(mem_rdata >> {off_q, 3'b000});
    half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_c = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_c = {{16{half_v[15]}}, half_v};
      3'b100:  load_c = {24'h0, byte_v};
      3'b101:  load_c = {16'h0, half_v};
      default: load_c = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == S_REQ && mem_gnt)
      wait_cnt <= '0;
    else if (state == S_WAIT && !mem_rvalid)
      wait_cnt <= wait_cnt + CW'(1);
  end

  assign timeout_hit = (state == S_WAIT) && !mem_rvalid && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept && !bad)
          state_next = S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid || timeout_hit)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q      <= 1'b0;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      rd_q            <= 5'd0;
      mem_we          <= 1'b0;
      mem_addr        <= 32'h0;
      mem_wdata       <= 32'h0;
      mem_wstrb       <= 4'h0;
      wb_rd_addr      <= 5'd0;
      wb_data         <= 32'h0;
      wb_write_enable <= 1'b0;
      fault           <= 1'b0;
    end else begin
      wb_write_enable <= 1'b0;
      fault           <= timeout_hit;
      if (accept) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        off_q      <= addr[1:0];
        rd_q       <= rd_addr_in;
        mem_we     <= is_store;
        mem_addr   <= {addr[31:2], 2'b00};
        mem_wdata  <= wdata_c;
        mem_wstrb  <= wstrb_c;
        fault      <= bad;
      end
      // x0 is hardwired zero, so its loads never reach the register file.
      if (rsp_hit && !is_store_q && rd_q != 5'd0) begin
        wb_write_enable <= 1'b1;
        wb_rd_addr      <= rd_q;
        wb_data         <= load_c;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model checked every cycle plus hand-computed literals.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic [4:0]  rd_addr_in = 5'd0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        req_ready, mem_req, mem_we, wb_write_enable, fault, busy;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rd_addr;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .rd_addr_in(rd_addr_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .wb_write_enable(wb_write_enable), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level helpers: access size in bytes, legality, lanes and extension.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit op_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b11) return 1;
    if (st && f3[2]) return 1;
    if (!st && f3 == 3'b110) return 1;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_strb(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!st) return 4'b0000;
    n = nbytes(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (nbytes(f3))
      1:       return (sd & 32'hFF) * 32'h01010101;
      2:       return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    longint nb, v;
    nb = 8 * nbytes(f3);
    v  = longint'(w) >> (8 * (a % 4));
    v  = v & ((longint'(1) << nb) - 1);
    if (!f3[2] && nb < 32 && ((v >> (nb - 1)) & 1) == 1)
      v = v - (longint'(1) << nb);
    return v[31:0];
  endfunction

  // Transaction model: phase 0 idle, 1 requesting, 2 awaiting response.
  int          m_phase = 0, m_wcnt = 0;
  bit          m_wb = 0, m_fault = 0, m_st = 0;
  logic [2:0]  m_f3 = 3'b000;
  logic [31:0] m_a = 32'h0, m_sd = 32'h0, m_wb_data = 32'h0;
  logic [4:0]  m_rd = 5'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_wb    = 0;
    m_fault = 0;
    if (rst) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          if (op_bad(is_store, funct3, addr)) m_fault = 1;
          else begin
            m_phase = 1; m_st = is_store; m_f3 = funct3; m_a = addr;
            m_sd = store_data; m_rd = rd_addr_in;
          end
        end
        1: if (mem_gnt) begin m_phase = 2; m_wcnt = 0; end
        default: begin
          if (mem_rvalid) begin
            m_phase = 0;
            if (!m_st && m_rd != 0) begin
              m_wb = 1; m_wb_data = ld_ext(m_f3, m_a, mem_rdata);
            end
          end else begin
`ifdef LSU_TIMEOUT_EN
            m_wcnt++;
            if (m_wcnt == TO) begin m_phase = 0; m_fault = 1; end
`endif
          end
        end
      endcase
    end
  end

  int          wb_cnt = 0, fault_cnt = 0, req_cyc_cnt = 0, acc_cyc = 0, wb_cyc = 0;
  logic [31:0] last_req_addr = 32'h0, last_req_wdata = 32'h0;
  logic [3:0]  last_req_strb = 4'h0;

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", req_ready, m_phase == 0);
      chk("busy", busy, m_phase != 0);
      chk("mem_req", mem_req, m_phase == 1);
      chk("fault", fault, m_fault);
      chk("wb_we", wb_write_enable, m_wb);
      if (m_phase == 1) begin
        chk("mem_addr", mem_addr, {m_a[31:2], 2'b00});
        chk("mem_we", mem_we, m_st);
        chk("mem_wstrb", mem_wstrb, exp_strb(m_st, m_f3, m_a));
        if (m_st) chk("mem_wdata", mem_wdata, exp_wdata(m_f3, m_sd));
      end
      if (m_wb) begin
        chk("wb_data", wb_data, m_wb_data);
        chk("wb_rd", wb_rd_addr, m_rd);
      end
      if (wb_write_enable) begin wb_cnt++; wb_cyc = cyc; end
      if (fault) fault_cnt++;
      if (mem_req) begin
        req_cyc_cnt++;
        last_req_addr = mem_addr; last_req_strb = mem_wstrb; last_req_wdata = mem_wdata;
      end
      if (req_valid && req_ready) acc_cyc = cyc;
    end
  end

  // Called #1 after a posedge with the DUT idle; returns #1 into the cycle after the response.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] rdat);
    req_valid = 1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd_addr_in = rd;
    @(posedge clk); #1;
    req_valid = 0;
    if (op_bad(st, f3, a)) return;
    mem_rvalid = (gd > 0);
    mem_rdata  = 32'h5A5A5A5A;
    for (int i = 0; i < gd; i++) begin mem_gnt = 0; @(posedge clk); #1; end
    mem_rvalid = 0; mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    for (int i = 0; i < rvd; i++) begin @(posedge clk); #1; end
    mem_rvalid = 1; mem_rdata = rdat;
    @(posedge clk); #1;
    mem_rvalid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  int wb0, f0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_wb_rd", wb_rd_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_we", wb_write_enable, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ready", req_ready, 1);
    @(posedge clk); #1;
    rst = 0; started = 1;
    idle(1);

    // LW with minimum latency
    do_op(0, 3'b010, 32'h100, 0, 5'd5, 0, 0, 32'hDEADBEEF);
    chk("lw_pulse", wb_write_enable, 1);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_rd", wb_rd_addr, 5);
    chk("lw_ready_in_pulse", req_ready, 1);
    idle(1);
    chk("lw_latency", wb_cyc - acc_cyc, 3);
    chk("lw_addr", last_req_addr, 32'h100);
    chk("lw_strb", last_req_strb, 4'b0000);
    chk("lw_one_pulse", wb_cnt, 1);

    // LB then LBU back-to-back in the writeback cycle
    do_op(0, 3'b000, 32'h103, 0, 5'd6, 0, 0, 32'h80FF1234);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    do_op(0, 3'b100, 32'h103, 0, 5'd7, 0, 1, 32'h80FF1234);
    chk("lbu_data", wb_data, 32'h00000080);
    chk("lbu_rd", wb_rd_addr, 7);
    idle(1);
    do_op(0, 3'b101, 32'h202, 0, 5'd8, 1, 0, 32'hBEEF0000);
    chk("lhu_data", wb_data, 32'h0000BEEF);
    idle(1);
    do_op(0, 3'b001, 32'h202, 0, 5'd9, 0, 2, 32'hBEEF0000);
    chk("lh_data", wb_data, 32'hFFFFBEEF);
    idle(1);

    // SB with grant held off three cycles
    wb0 = wb_cnt; req_cyc_cnt = 0;
    do_op(1, 3'b000, 32'h301, 32'h000000AB, 5'd3, 3, 0, 32'h0);
    chk("sb_no_pulse", wb_write_enable, 0);
    idle(1);
    chk("sb_req_cycles", req_cyc_cnt, 4);
    chk("sb_strb", last_req_strb, 4'b0010);
    chk("sb_wdata", last_req_wdata, 32'hABABABAB);
    chk("sb_no_wb", wb_cnt, wb0);

    // Faults: misaligned LW, illegal store funct3
    f0 = fault_cnt; req_cyc_cnt = 0;
    do_op(0, 3'b010, 32'h102, 0, 5'd4, 0, 0, 32'h0);
    chk("lw_mis_fault", fault, 1);
    chk("lw_mis_ready", req_ready, 1);
    idle(1);
    do_op(1, 3'b011, 32'h400, 32'h1234, 5'd4, 0, 0, 32'h0);
    chk("sh_ill_fault", fault, 1);
    chk("sh_ill_ready", req_ready, 1);
    idle(2);
    chk("fault_count", fault_cnt - f0, 2);
    chk("fault_no_req", req_cyc_cnt, 0);

    // LW to x0 completes without writeback
    wb0 = wb_cnt;
    do_op(0, 3'b010, 32'h500, 0, 5'd0, 0, 0, 32'h12345678);
    chk("rd0_no_pulse", wb_write_enable, 0);
    idle(1);
    chk("rd0_no_wb", wb_cnt, wb0);

    do_op(1, 3'b010, 32'h600, 32'h12345678, 5'd1, 1, 2, 32'h0);
    idle(1);
    chk("sw_strb", last_req_strb, 4'b1111);
    chk("sw_wdata", last_req_wdata, 32'h12345678);
    do_op(1, 3'b001, 32'h702, 32'hCAFE5678, 5'd1, 0, 0, 32'h0);
    idle(1);
    chk("sh_strb", last_req_strb, 4'b1100);
    chk("sh_wdata", last_req_wdata, 32'h56785678);

`ifdef LSU_TIMEOUT_EN
    wb0 = wb_cnt; f0 = fault_cnt;
    req_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h800; rd_addr_in = 5'd10;
    @(posedge clk); #1; req_valid = 0; mem_gnt = 1;
    @(posedge clk); #1; mem_gnt = 0;
    idle(7);
    chk("to_fault", fault_cnt - f0, 1);
    chk("to_no_wb", wb_cnt, wb0);
    chk("to_idle", req_ready, 1);
`endif

    // Reset while waiting for the response; a late rvalid must be ignored
    wb0 = wb_cnt; f0 = fault_cnt;
    req_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h900; rd_addr_in = 5'd11;
    @(posedge clk); #1; req_valid = 0; mem_gnt = 1;
    @(posedge clk); #1; mem_gnt = 0; rst = 1;
    @(posedge clk); #1; rst = 0;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_req", mem_req, 0);
    mem_rvalid = 1; mem_rdata = 32'h11111111;
    @(posedge clk); #1; mem_rvalid = 0;
    idle(2);
    chk("rst_mid_no_wb", wb_cnt, wb0);
    chk("rst_mid_no_fault", fault_cnt, f0);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
